// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative HI/LO multiply/divide unit for the MIPS datapath. Takes the two
// register-file read values for MULT/MULTU/DIV/DIVU, runs one shift-add
// (multiply) or restoring shift-subtract (divide) step per cycle, applies
// sign correction and loads the architectural HI/LO registers. MTHI/MTLO
// write HI/LO directly while the unit is idle.
//
// Build option:
//   MULT_DIV_DIV_EN  defined   -> full multiply + divide unit.
//                    undefined -> divide datapath removed; a start with
//                                 op[1]=1 is ignored entirely.
//
// Ports:
//   clk     in   1      clock, rising edge
//   reset   in   1      synchronous active-high reset
//   start   in   1      begin an operation (accepted only when idle)
//   op      in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val  in   WIDTH  multiplicand / dividend
//   rt_val  in   WIDTH  multiplier / divisor
//   mthi    in   1      write wd into HI
//   mtlo    in   1      write wd into LO
//   wd      in   WIDTH  MTHI/MTLO data
//   busy    out  1      operation in progress (registered)
//   done    out  1      one-cycle pulse when HI/LO take a new result
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
//
// Timing for a start accepted at edge T: busy is high after edges
// T+1..T+WIDTH+1; HI/LO load and done pulses at edge T+WIDTH+2.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             wr_pend;
  logic             idle_free;
  logic             accept;
  logic             last_step;

  // Shared datapath: acc_hi is the partial product high half or the
  // running remainder; acc_lo is the multiplier being shifted out or the
  // dividend being shifted out / quotient being shifted in.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mag_b;
  logic             neg_p;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

`ifdef MULT_DIV_DIV_EN
  logic             op_div;
  logic             neg_r;
  logic             div0;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
`endif

  // Absolute value for signed operations; 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (sgn && (sv < 0)) return -v;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] v,
                                                     input logic               neg);
    return neg ? -v : v;
  endfunction

  // The cycle in which the result is being written to HI/LO still has
  // busy high, so the unit is only free once both state and busy agree.
  assign idle_free = (state == IDLE) && !busy;

`ifdef MULT_DIV_DIV_EN
  assign accept = idle_free && start;
`else
  assign accept = idle_free && start && !op[1];
`endif

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last_step) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mul_sum          = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    step_hi          = mul_sum[WIDTH:1];
    step_lo          = {mul_sum[0], acc_lo[WIDTH-1:1]};
    {fix_hi, fix_lo} = cond_neg_dw({acc_hi, acc_lo}, neg_p);
`ifdef MULT_DIV_DIV_EN
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    if (op_div) begin
      // Remainder is always below the divisor, so the restored value
      // fits in WIDTH bits and modulo subtraction is exact.
      step_hi = div_shift[WIDTH-1:0] - (div_ge ? mag_b : '0);
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
      fix_hi  = cond_neg_w(acc_hi, neg_r);
      // A zero divisor leaves |rs| in the remainder, so the sign fix
      // restores rs exactly; only the quotient needs forcing.
      fix_lo  = div0 ? '1 : cond_neg_w(acc_lo, neg_p);
    end
`endif
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_pend <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_nx;
      busy    <= (state != IDLE);
      wr_pend <= (state == FIX);
      done    <= wr_pend;
      if (accept) begin
        cnt <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wr_pend) begin
        hi <= acc_hi;
        lo <= acc_lo;
      end else if (idle_free && !accept) begin
        if (mthi) hi <= wd;
        if (mtlo) lo <= wd;
      end
    end
  end

  // Operand latch / iteration / sign-fix datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi <= '0;
      acc_lo <= magnitude(rs_val, op[0]);
      mag_b  <= magnitude(rt_val, op[0]);
      neg_p  <= op[0] & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
`ifdef MULT_DIV_DIV_EN
      op_div <= op[1];
      neg_r  <= op[0] & rs_val[WIDTH-1];
      div0   <= (rt_val == '0);
`endif
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end else if (state == FIX) begin
      acc_hi <= fix_hi;
      acc_lo <= fix_lo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wd     (wd),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one operation and watch 40 cycles after the accepting edge.
  // Operands are scrambled right after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l,
                        output int lat, output int bcnt, output int dcnt,
                        output logic busy_t0);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = ~a; rt_val = ~b;
    busy_t0 = busy;
    lat = 0; bcnt = 0; dcnt = 0; h = hi; l = lo;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = k;
        h = hi; l = lo;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_multu_max();
    logic [31:0] h, l; int lat, bcnt, dcnt; logic b0;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l, lat, bcnt, dcnt, b0);
    checks++; if (h !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_max_hi: got %h expected fffffffe", h); end
    checks++; if (l !== 32'h00000001) begin failures++; $display("FAIL multu_max_lo: got %h expected 00000001", l); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    checks++; if (bcnt !== 33) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected 33", bcnt); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL multu_done_count: got %0d expected 1", dcnt); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL busy_after_accept: got %b expected 0", b0); end
  endtask

  task automatic test_mult_signed();
    logic [31:0] h, l; int lat, bcnt, dcnt; logic b0;
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, h, l, lat, bcnt, dcnt, b0);
    checks++; if (h !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_m3x7_hi: got %h expected ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_m3x7_lo: got %h expected ffffffeb", l); end
    run_op(2'b01, 32'h80000000, 32'h80000000, h, l, lat, bcnt, dcnt, b0);
    checks++; if (h !== 32'h40000000) begin failures++; $display("FAIL mult_minxmin_hi: got %h expected 40000000", h); end
    checks++; if (l !== 32'h00000000) begin failures++; $display("FAIL mult_minxmin_lo: got %h expected 00000000", l); end
    run_op(2'b01, 32'h80000000, 32'h00000001, h, l, lat, bcnt, dcnt, b0);
    checks++; if (h !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_minx1_hi: got %h expected ffffffff", h); end
    checks++; if (l !== 32'h80000000) begin failures++; $display("FAIL mult_minx1_lo: got %h expected 80000000", l); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL mult_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wd = 32'h55;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'h55) begin failures++; $display("FAIL mt_both_hi: got %h expected 00000055", hi); end
    checks++; if (lo !== 32'h55) begin failures++; $display("FAIL mt_both_lo: got %h expected 00000055", lo); end
    // MTHI/MTLO in the same cycle as an accepted start lose to the start
    @(negedge clk); start = 1'b1; op = 2'b00; rs_val = 32'd2; rt_val = 32'd3;
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h77;
    @(negedge clk); start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'h55) begin failures++; $display("FAIL mt_with_start_hi: got %h expected 00000055", hi); end
    checks++; if (lo !== 32'h55) begin failures++; $display("FAIL mt_with_start_lo: got %h expected 00000055", lo); end
    repeat (40) @(negedge clk);
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mt_start_result_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h6) begin failures++; $display("FAIL mt_start_result_lo: got %h expected 00000006", lo); end
  endtask

  task automatic test_busy_ignore();
    int lat, bcnt, dcnt;
    @(negedge clk); start = 1'b1; op = 2'b00; rs_val = 32'h00010000; rt_val = 32'h00010000;
    @(negedge clk); start = 1'b0;
    lat = 0; bcnt = 0; dcnt = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin dcnt++; if (lat == 0) lat = k; end
      if (k == 4) begin
        start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd5; mthi = 1'b1; wd = 32'h1234;
      end
      if (k == 5) begin start = 1'b0; mthi = 1'b0; end
    end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", dcnt); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
    checks++; if (bcnt !== 33) begin failures++; $display("FAIL ignore_busy_cycles: got %0d expected 33", bcnt); end
    checks++; if (hi !== 32'h1) begin failures++; $display("FAIL ignore_hi: got %h expected 00000001", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL ignore_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_reset_mid();
    int bcnt, dcnt;
    @(negedge clk); mtlo = 1'b1; wd = 32'h99;
    @(negedge clk); mtlo = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL midreset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL midreset_lo: got %h expected 00000000", lo); end
    bcnt = 0; dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL midreset_no_done: got %0d expected 0", dcnt); end
    checks++; if (bcnt !== 0) begin failures++; $display("FAIL midreset_no_busy: got %0d expected 0", bcnt); end
    @(negedge clk); mtlo = 1'b1; wd = 32'hABCD;
    @(negedge clk); mtlo = 1'b0;
    checks++; if (lo !== 32'hABCD) begin failures++; $display("FAIL mtlo_lo: got %h expected 0000abcd", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mtlo_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    @(negedge clk); start = 1'b1; op = 2'b00; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk); start = 1'b0;
    k1 = 0;
    for (int k = 1; k <= 40 && k1 == 0; k++) begin
      @(negedge clk);
      if (done) k1 = k;
    end
    checks++; if (k1 !== 34) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 34", k1); end
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL b2b_first_lo: got %h expected 00000006", lo); end
    start = 1'b1; rs_val = 32'd4; rt_val = 32'd5;
    @(negedge clk); start = 1'b0;
    k2 = 0;
    for (int k = 1; k <= 40 && k2 == 0; k++) begin
      @(negedge clk);
      if (done) k2 = k;
    end
    checks++; if (k2 !== 34) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 34", k2); end
    checks++; if (lo !== 32'd20) begin failures++; $display("FAIL b2b_second_lo: got %h expected 00000014", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL b2b_second_hi: got %h expected 00000000", hi); end
  endtask

`ifdef MULT_DIV_DIV_EN
  task automatic test_divide();
    logic [31:0] h, l; int lat, bcnt, dcnt; logic b0;
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_m7d2_lo: got %h expected fffffffd", l); end
    checks++; if (h !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_m7d2_hi: got %h expected ffffffff", h); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency: got %0d expected 34", lat); end
    run_op(2'b10, 32'h00000064, 32'h00000000, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_zero_lo: got %h expected ffffffff", l); end
    checks++; if (h !== 32'h00000064) begin failures++; $display("FAIL divu_zero_hi: got %h expected 00000064", h); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL divu_zero_latency: got %0d expected 34", lat); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo: got %h expected 80000000", l); end
    checks++; if (h !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi: got %h expected 00000000", h); end
    run_op(2'b10, 32'd100, 32'd7, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'd14) begin failures++; $display("FAIL divu_100d7_lo: got %h expected 0000000e", l); end
    checks++; if (h !== 32'd2) begin failures++; $display("FAIL divu_100d7_hi: got %h expected 00000002", h); end
    run_op(2'b11, 32'd7, 32'hFFFFFFFE, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_7dm2_lo: got %h expected fffffffd", l); end
    checks++; if (h !== 32'd1) begin failures++; $display("FAIL div_7dm2_hi: got %h expected 00000001", h); end
    run_op(2'b11, 32'hFFFFFFFB, 32'd0, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_zero_lo: got %h expected ffffffff", l); end
    checks++; if (h !== 32'hFFFFFFFB) begin failures++; $display("FAIL div_zero_hi: got %h expected fffffffb", h); end
  endtask
`else
  task automatic test_div_disabled();
    logic [31:0] h, l; int lat, bcnt, dcnt; logic b0;
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wd = 32'hDEAD;
    @(negedge clk); mthi = 1'b0; wd = 32'hBEEF;
    @(negedge clk); mtlo = 1'b0;
    run_op(2'b10, 32'd100, 32'd7, h, l, lat, bcnt, dcnt, b0);
    checks++; if (bcnt !== 0) begin failures++; $display("FAIL nodiv_busy_cycles: got %0d expected 0", bcnt); end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL nodiv_done_count: got %0d expected 0", dcnt); end
    checks++; if (hi !== 32'hDEAD) begin failures++; $display("FAIL nodiv_hi: got %h expected 0000dead", hi); end
    checks++; if (lo !== 32'hBEEF) begin failures++; $display("FAIL nodiv_lo: got %h expected 0000beef", lo); end
    run_op(2'b00, 32'd2, 32'd3, h, l, lat, bcnt, dcnt, b0);
    checks++; if (l !== 32'd6) begin failures++; $display("FAIL nodiv_multu_lo: got %h expected 00000006", l); end
    checks++; if (h !== 32'd0) begin failures++; $display("FAIL nodiv_multu_hi: got %h expected 00000000", h); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL nodiv_multu_latency: got %0d expected 34", lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef MULT_DIV_DIV_EN
    test_divide();
`else
    test_div_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath, downstream of the register file. It consumes the two register-file read values (rs, rt) for MULT/MULTU/DIV/DIVU and computes the result over several cycles with a start/busy/done handshake. It holds the architectural HI and LO registers, which are read by MFHI/MFLO and written directly by MTHI/MTLO. Decode/hazard logic stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin an operation; accepted only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs_val`  in  WIDTH  multiplicand or dividend (register-file RD1).
- `rt_val`  in  WIDTH  multiplier or divisor (register-file RD2).
- `mthi`  in  1  write `wd` into HI.
- `mtlo`  in  1  write `wd` into LO.
- `wd`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  WIDTH  HI register (product high half or remainder).
- `lo`  out  WIDTH  LO register (product low half or quotient).

## Operation
- FSM states:
  - IDLE: on `start`, latch operand magnitudes (absolute values for signed ops), result sign(s) and `op`; clear the counter; go to CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly `WIDTH` cycles, then go to FIX.
  - FIX: apply sign correction, load `hi`/`lo`, pulse `done`, go to IDLE.
- Multiply: `{hi,lo}` = full 2·WIDTH-bit product, computed signed for MULT and unsigned for MULTU.
- Divide:
  - `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend.
  - Divisor zero (DIV or DIVU): `lo`=all ones, `hi`=`rs_val`, with full normal latency.
  - DIV of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Operands are sampled only on the accepting edge; later changes to `rs_val`/`rt_val` have no effect.
- MTHI/MTLO:
  - In IDLE without `start`: write on the next edge.
  - Ignored while `busy`.
  - Ignored in the same cycle as an accepted `start`, which has priority.
  - `mthi` and `mtlo` may both be asserted; both write.
- `start` while `busy`: ignored; it is neither queued nor restarts the operation.
- `hi`/`lo` hold their previous values until FIX.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- With `start` accepted at edge T:
  - `busy`=1 after edges T+1 … T+WIDTH+1.
  - At edge T+WIDTH+2: `hi`/`lo` updated, `done`=1 for that one cycle, `busy`=0.
- Latency is `WIDTH`+2 cycles (34 for 32-bit), fixed and data-independent.
- A new `start` may be asserted in the same cycle that `done`=1; it is accepted on the next edge, giving back-to-back operations.
- `reset` mid-operation: the next edge returns to IDLE with all outputs at reset values; the partial result is discarded and no `done` is produced.
- `busy` and `done` are registered outputs.

## Configuration
- `MULT_DIV_DIV_EN` defined: full unit as specified above.
- Not defined:
  - Divide datapath is removed.
  - `start` with `op[1]`=1 is ignored: `busy` stays 0, no `done` is produced, and `hi`/`lo` are unchanged.
  - Multiply, MTHI and MTLO behave as specified.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `start` at T -> `done` at T+34, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000007 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; then DIV 0xFFFFFFF9 (−7) ÷ 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 0x64 ÷ 0 -> `lo`=0xFFFFFFFF, `hi`=0x64 at T+34; DIV 0x80000000 ÷ 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- During a MULTU: a second `start` and `mthi` with `wd`=0x1234 at T+5 -> both ignored, result equals the first operation only, exactly one `done`.
- `reset` asserted at T+10 of a MULT -> next cycle `busy`=0, `hi`=`lo`=0, no `done`; then `mtlo` with `wd`=0xABCD in IDLE -> `lo`=0xABCD next cycle, `hi` still 0.
- Without `MULT_DIV_DIV_EN`: DIVU `start` -> `busy` stays 0 and `hi`/`lo` unchanged for 40 cycles; a following MULTU 2×3 -> `lo`=6, `hi`=0.
